ofmap_drain: RTL and testbench

OFMAP_DRAIN -- requirements
Module: ofmap_drain

---
 rtl/ofmap_drain.sv | 151 +++++++++++++++
 tb/tb_ofmap_drain.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_drain.sv
// ofmap_drain: drains int32 psums from the GLB, requantises each to int8
// and streams them out packed four lanes per word with a byte keep mask.
// Ports: clk, rst (async, active high);
//   cmd    : start, opsum_baseaddr, num_words, shift, relu_en;
//   glb    : glb_re, glb_r_addr -> glb_r_data (one-cycle read latency);
//   stream : out_valid, out_ready, out_data, out_keep, out_last;
//   status : busy, done (one-cycle pulse at the end of a drain).
module ofmap_drain #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          opsum_baseaddr,
  input  logic [15:0]          num_words,
  input  logic [4:0]           shift,
  input  logic                 relu_en,
  output logic [3:0]           glb_re,
  output logic [31:0]          glb_r_addr,
  input  logic [DATA_SIZE-1:0] glb_r_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [3:0]           out_keep,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    OUT,
    FINISH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [15:0]          idx;
  logic [DATA_SIZE-1:0] pack;
  logic [3:0]           keep;
  logic [1:0]           lane;
  logic                 last_psum;

  logic signed [32:0] q_ext;
  logic signed [32:0] q_rnd;
  logic signed [32:0] q_sum;
  logic signed [32:0] q_shf;
  logic [7:0]         q_byte;

  assign lane      = idx[1:0];
  assign last_psum = (idx + 16'd1) == num_words;

  // 33 bits keep x + 2^30 from overflowing before the shift.
  always_comb begin
    q_ext = {glb_r_data[31], glb_r_data[31:0]};
    q_rnd = '0;
    if (shift != 5'd0) begin
      q_rnd[shift - 5'd1] = 1'b1;
    end
    q_sum  = q_ext + q_rnd;
    q_shf  = q_sum >>> shift;
    q_byte = q_shf[7:0];
    if (relu_en && q_shf[32]) begin
      q_byte = 8'h00;
    end else if (q_shf > 33'sd127) begin
      q_byte = 8'h7f;
    end else if (q_shf < -33'sd128) begin
      q_byte = 8'h80;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (num_words != 16'd0) ? READ : FINISH;
        end
      end
      READ: begin
        state_nx = CAPTURE;
      end
      CAPTURE: begin
        if (lane == 2'd3 || last_psum) begin
          state_nx = OUT;
        end else begin
          state_nx = READ;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nx = out_last ? FINISH : READ;
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      pack  <= '0;
      keep  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx <= '0;
          end
        end
        CAPTURE: begin
          pack[{lane, 3'b000} +: 8] <= q_byte;
          keep[lane]                <= 1'b1;
          idx                       <= idx + 16'd1;
        end
        OUT: begin
          if (out_ready) begin
            pack <= '0;
            keep <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Address wraps naturally in the 32-bit add.
  assign glb_re     = (state == READ) ? 4'hf : 4'h0;
  assign glb_r_addr = (state == READ)
                    ? opsum_baseaddr + {14'd0, idx, 2'b00}
                    : 32'd0;

  assign out_valid = (state == OUT);
  assign out_data  = pack;
  assign out_keep  = keep;
  assign out_last  = (state == OUT) && (idx == num_words);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

endmodule

// File: tb/tb_ofmap_drain.sv
// tb_ofmap_drain: scoreboard bench for ofmap_drain.
// GLB model answers reads; a monitor pops expected reads and words.
module tb_ofmap_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] opsum_baseaddr;
  logic [15:0] num_words;
  logic [4:0]  shift;
  logic        relu_en;
  logic [3:0]  glb_re;
  logic [31:0] glb_r_addr;
  logic [31:0] glb_r_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        busy;
  logic        done;

  ofmap_drain #(.DATA_SIZE(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .opsum_baseaddr (opsum_baseaddr),
    .num_words      (num_words),
    .shift          (shift),
    .relu_en        (relu_en),
    .glb_re         (glb_re),
    .glb_r_addr     (glb_r_addr),
    .glb_r_data     (glb_r_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_keep       (out_keep),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t        wq[$];
  logic [31:0] aq[$];
  logic [31:0] mem [16];
  logic [31:0] cur_base;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int hs_cnt = 0;
  int hs_last_cyc = 0;
  int c0 = 0;
  logic [31:0] last_word = '0;
  logic        held = 1'b0;
  logic [31:0] held_d = '0;
  bit          rdy_mode = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] q8(input logic [31:0] x,
                                    input logic [4:0] sh,
                                    input logic re);
    longint v;
    v = longint'($signed(x));
    if (sh != 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (re && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    logic [31:0] off;
    off = glb_r_addr - cur_base;
    if (glb_re == 4'hf) glb_r_data <= mem[off[5:2]];
  end

  always @(posedge clk) begin
    if (rdy_mode) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (glb_re != 4'h0) begin
        chk("re_val", glb_re, 4'hf);
        chk("rd_pending", aq.size() != 0, 1);
        if (aq.size() != 0) begin
          a = aq.pop_front();
          chk("rd_addr", glb_r_addr, a);
        end
      end
      if (out_valid && held) chk("hold_data", out_data, held_d);
      held   = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin
        chk("wr_pending", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("data", out_data, e.d);
          chk("keep", out_keep, e.k);
          chk("last", out_last, e.l);
        end
        hs_cnt++;
        last_word = out_data;
        if (out_last) hs_last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic prep(input logic [31:0] base, input int n,
                      input logic [4:0] sh, input logic re,
                      output int words);
    exp_t e;
    logic [31:0] w;
    logic [3:0] k;
    w = '0;
    k = '0;
    words = 0;
    for (int j = 0; j < n; j++) begin
      aq.push_back(base + 32'(4 * j));
      w[8 * (j % 4) +: 8] = q8(mem[j], sh, re);
      k[j % 4] = 1'b1;
      if (j % 4 == 3 || j == n - 1) begin
        e.d = w;
        e.k = k;
        e.l = (j == n - 1);
        wq.push_back(e);
        w = '0;
        k = '0;
        words++;
      end
    end
  endtask

  task automatic go(input logic [31:0] base, input int n,
                    input logic [4:0] sh, input logic re);
    @(posedge clk);
    #1;
    cur_base       = base;
    opsum_baseaddr = base;
    num_words      = 16'(n);
    shift          = sh;
    relu_en        = re;
    start          = 1'b1;
    c0             = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish(input int words, input int d0, input int h0,
                        input int n, input bit timed);
    for (int t = 0; t < 4000 && done_cnt == d0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("words", hs_cnt - h0, words);
    chk("rd_left", aq.size(), 0);
    chk("wr_left", wq.size(), 0);
    chk("idle", busy, 0);
    if (timed) chk("cycles", done_cyc - c0, 2 * n + words + 1);
  endtask

  task automatic drain(input logic [31:0] base, input int n,
                       input logic [4:0] sh, input logic re,
                       input bit poke, input bit timed);
    int words, d0, h0;
    prep(base, n, sh, re, words);
    d0 = done_cnt;
    h0 = hs_cnt;
    go(base, n, sh, re);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    finish(words, d0, h0, n, timed);
  endtask

  task automatic fill_rand(input int n);
    for (int j = 0; j < n; j++) begin
      if (j % 2 == 0) mem[j] = $urandom();
      else mem[j] = 32'(int'($urandom_range(0, 4000)) - 2000);
    end
  endtask

  initial begin
    int words, d0, h0, seen, n;
    logic [31:0] d;
    rst = 1'b1;
    start = 1'b0;
    opsum_baseaddr = '0;
    num_words = '0;
    shift = '0;
    relu_en = 1'b0;
    out_ready = 1'b1;
    cur_base = '0;
    glb_r_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_re", glb_re, 0);
    chk("rst_addr", glb_r_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    mem[0] = 32'd1;
    mem[1] = -32'sd2;
    mem[2] = 32'd127;
    mem[3] = 32'd200;
    drain(32'h100, 4, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("ex1_word", last_word, 32'h7f7ffe01);
    chk("ex1_done_lat", done_cyc - hs_last_cyc, 1);

    mem[0] = 32'd24;
    mem[1] = -32'sd40;
    mem[2] = 32'd8;
    mem[3] = 32'd7;
    mem[4] = -32'sd1;
    mem[5] = 32'd4096;
    drain(32'h2000, 6, 5'd4, 1'b1, 1'b0, 1'b1);
    chk("ex2_word1", last_word, 32'h00007f00);

    fill_rand(5);
    prep(32'hffff_fff8, 5, 5'd3, 1'b0, words);
    d0 = done_cnt;
    h0 = hs_cnt;
    out_ready = 1'b0;
    go(32'hffff_fff8, 5, 5'd3, 1'b0);
    for (int t = 0; t < 100 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_reach", out_valid, 1);
    d = out_data;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, d);
      chk("bp_re", glb_re, 0);
    end
    out_ready = 1'b1;
    finish(words, d0, h0, 5, 1'b0);

    drain(32'h300, 0, 5'd0, 1'b0, 1'b0, 1'b1);

    for (int j = 0; j < 4; j++) mem[j] = 32'(j * 300 - 500);
    prep(32'h400, 4, 5'd2, 1'b0, words);
    d0 = done_cnt;
    go(32'h400, 4, 5'd2, 1'b0);
    seen = 0;
    for (int t = 0; t < 50 && seen < 2; t++) begin
      @(negedge clk);
      if (glb_re == 4'hf) seen++;
    end
    #1;
    rst = 1'b1;
    #1;
    chk("mid_re", glb_re, 0);
    chk("mid_addr", glb_r_addr, 0);
    chk("mid_valid", out_valid, 0);
    chk("mid_data", out_data, 0);
    chk("mid_keep", out_keep, 0);
    chk("mid_last", out_last, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    aq.delete();
    wq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_done", done_cnt - d0, 0);
    fill_rand(4);
    drain(32'h400, 4, 5'd1, 1'b1, 1'b0, 1'b1);

    fill_rand(8);
    drain(32'h500, 8, 5'd2, 1'b0, 1'b1, 1'b1);

    rdy_mode = 1'b1;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 12);
      fill_rand(n);
      drain($urandom() & 32'hffff_fffc, n, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    rdy_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
